// File: rtl/udma_cam_pix_packer.sv
// udma_cam_pix_packer: packs camera pixels (PIX_WIDTH) into little-endian
// DATA_WIDTH words for the uDMA RX channel, through a small output FIFO.
// Frames are framed by vsync (level) and lines by hsync (level); a frame is
// only captured if cfg_en_i is high at the vsync rising edge.
// Optional feature: define CAM_PACK_PIXCNT_EN to build a per-frame pixel
// counter reported on frame_pix_o (tied to zero otherwise).
//
// Handshake: a word moves from data_o to the consumer on a rising clk_i edge
// where valid_o=1 and ready_i=1; while valid_o=1 and ready_i=0, data_o and
// valid_o hold their values.
module udma_cam_pix_packer #(
    parameter int PIX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic                  pix_valid_i,
    input  logic [PIX_WIDTH-1:0]  pix_data_i,
    input  logic                  vsync_i,
    input  logic                  hsync_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_start_o,
    output logic                  overflow_o,
    output logic [19:0]           frame_pix_o,
    output logic [1:0]            state_o
);

    localparam int PPW = DATA_WIDTH / PIX_WIDTH;
    localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PPW - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  vsync_q;
    logic                  vsync_rise;
    logic                  start_frame;
    logic                  accept;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  full;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0] pack_ins;
    logic [CW-1:0]         byte_cnt_q;
    logic                  frame_start_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;

    // vsync_q resets high so a vsync already active at reset release is not an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) vsync_q <= 1'b1;
        else       vsync_q <= vsync_i;
    end

    assign vsync_rise = vsync_i & ~vsync_q;

    // Frame state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, pixel acceptance and word push selection
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        push_data   = pack_q;
        case (state_q)
            ST_IDLE: begin
                if (vsync_rise && cfg_en_i) begin
                    state_d     = ST_FRAME;
                    start_frame = 1'b1;
                end
            end
            ST_FRAME: begin
                accept = pix_valid_i & hsync_i;
                if (accept && (byte_cnt_q == LAST_SLOT)) begin
                    push      = 1'b1;
                    push_data = pack_ins;
                end
                if (!vsync_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // pack_q is zero above the filled slots, so the partial word is zero-padded
                if (byte_cnt_q != '0) push = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Current partial word with the incoming pixel dropped into its slot
    always_comb begin
        pack_ins = pack_q;
        pack_ins[int'(byte_cnt_q) * PIX_WIDTH +: PIX_WIDTH] = pix_data_i;
    end

    // Packing register: cleared after every full word and by the flush
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == ST_FLUSH)) begin
            byte_cnt_q <= '0;
            pack_q     <= '0;
        end else if (accept) begin
            if (byte_cnt_q == LAST_SLOT) begin
                byte_cnt_q <= '0;
                pack_q     <= '0;
            end else begin
                byte_cnt_q <= byte_cnt_q + CW'(1);
                pack_q     <= pack_ins;
            end
        end
    end

    assign full    = (count_q == FULL_CNT);
    assign pop     = valid_o & ready_i;
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    // FIFO storage; a full FIFO being popped may be written in the same cycle
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem[rd_ptr_q] : '0;

    // Frame-start pulse one cycle after the accepted vsync edge
    always_ff @(posedge clk_i) begin
        if (rst_i) frame_start_q <= 1'b0;
        else       frame_start_q <= start_frame;
    end

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i)          overflow_q <= 1'b0;
        else if (ovf_set)   overflow_q <= 1'b1;
        else if (cfg_clr_i) overflow_q <= 1'b0;
    end

    assign frame_start_o = frame_start_q;
    assign overflow_o    = overflow_q;
    assign state_o       = state_q;

`ifdef CAM_PACK_PIXCNT_EN
    logic [19:0] pix_cnt_q;
    logic [19:0] pix_cnt_inc;
    logic [19:0] frame_pix_q;

    assign pix_cnt_inc = (accept && (pix_cnt_q != 20'hFFFFF)) ? pix_cnt_q + 20'd1 : pix_cnt_q;

    // Saturating pixel counter; snapshot includes a pixel taken on the last FRAME cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_cnt_q   <= '0;
            frame_pix_q <= '0;
        end else begin
            if (start_frame) pix_cnt_q <= '0;
            else             pix_cnt_q <= pix_cnt_inc;
            if ((state_q == ST_FRAME) && (state_d == ST_FLUSH)) frame_pix_q <= pix_cnt_inc;
        end
    end

    assign frame_pix_o = frame_pix_q;
`else
    assign frame_pix_o = '0;
`endif

endmodule

// File: tb/tb_udma_cam_pix_packer.sv
// Testbench for udma_cam_pix_packer: per-cycle vector tables for whole
// frames, plus hand-written sequences for overflow, full-FIFO push/pop and
// reset in mid-frame.
module tb_udma_cam_pix_packer;

    localparam int PW = 8;
    localparam int DW = 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
`ifdef CAM_PACK_PIXCNT_EN
    localparam bit PIXCNT = 1'b1;
`else
    localparam bit PIXCNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic          cfg_clr;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          vsync;
    logic          hsync;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          frame_start;
    logic          overflow;
    logic [19:0]   frame_pix;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          vs, hs, pv;
        logic [PW-1:0] pix;
        logic          rdy, en, clr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          efs, eovf;
        logic [1:0]    est;
    } vec_t;

    vec_t vecs[$];

    udma_cam_pix_packer #(.PIX_WIDTH(PW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data), .vsync_i(vsync), .hsync_i(hsync),
        .data_o(data), .valid_o(valid), .ready_i(ready), .frame_start_o(frame_start),
        .overflow_o(overflow), .frame_pix_o(frame_pix), .state_o(state)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // apply inputs, clock once, sample outputs 1 ns after the edge
    task automatic drive(input logic vs, hs, pv, input logic [PW-1:0] pix, input logic rdy, en, clr);
        vsync = vs; hsync = hs; pix_valid = pv; pix_data = pix;
        ready = rdy; cfg_en = en; cfg_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic vs, hs, pv, input logic [PW-1:0] pix, input logic rdy, en, clr,
                       input logic ev, input logic [DW-1:0] ed, input logic efs, eovf,
                       input logic [1:0] est);
        vec_t v;
        v.vs = vs; v.hs = hs; v.pv = pv; v.pix = pix; v.rdy = rdy; v.en = en; v.clr = clr;
        v.ev = ev; v.ed = ed; v.efs = efs; v.eovf = eovf; v.est = est;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vs, vecs[i].hs, vecs[i].pv, vecs[i].pix, vecs[i].rdy, vecs[i].en, vecs[i].clr);
            check($sformatf("%s[%0d] valid", tag, i), 32'(valid), 32'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("%s[%0d] data", tag, i), data, vecs[i].ed);
            check($sformatf("%s[%0d] frame_start", tag, i), 32'(frame_start), 32'(vecs[i].efs));
            check($sformatf("%s[%0d] overflow", tag, i), 32'(overflow), 32'(vecs[i].eovf));
            check($sformatf("%s[%0d] state", tag, i), 32'(state), 32'(vecs[i].est));
        end
        vecs.delete();
    endtask

    // scoreboard drain: compare every word handed over against exp_q
    task automatic drain(input string tag, input int expn);
        int got = 0;
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid) begin
                got++;
                if (exp_q.size() > 0) check($sformatf("%s word%0d", tag, got), data, exp_q.pop_front());
            end
        end
        check($sformatf("%s word_count", tag), 32'(got), 32'(expn));
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset data", data, 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset frame_pix", 32'(frame_pix), 32'd0);
        check("reset state", 32'(state), 32'(S_IDLE));
        rst = 1'b0;

        // 8-pixel frame, ready high
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 1, 0, S_FRAME);
        add(1, 1, 1, 8'h01, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h02, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h03, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h04, 1, 1, 0, 1, 32'h04030201, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h05, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h06, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h07, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h08, 1, 1, 0, 1, 32'h08070605, 0, 0, S_FRAME);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_FLUSH);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_IDLE);
        run_vecs("frame8");
        check("frame8 frame_pix", 32'(frame_pix), PIXCNT ? 32'd8 : 32'd0);

        // 6-pixel frame with an hsync-low pixel and a pixel during FLUSH
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 1, 0, S_FRAME);
        add(1, 1, 1, 8'hA1, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'hA2, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 0, 1, 8'hFF, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'hA3, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'hA4, 1, 1, 0, 1, 32'hA4A3A2A1, 0, 0, S_FRAME);
        add(1, 1, 1, 8'hA5, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'hA6, 1, 1, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_FLUSH);
        add(0, 1, 1, 8'hEE, 1, 1, 0, 1, 32'h0000A6A5, 0, 0, S_IDLE);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 0, S_IDLE);
        run_vecs("frame6");
        check("frame6 frame_pix", 32'(frame_pix), PIXCNT ? 32'd6 : 32'd0);

        // frame ignored with cfg_en low, then cfg_en dropped mid-frame
        add(1, 0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 1, 1, 8'h11, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 1, 1, 8'h12, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 1, 1, 8'h13, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 1, 1, 8'h14, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 32'h0, 1, 0, S_FRAME);
        add(1, 1, 1, 8'h21, 1, 0, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h22, 1, 0, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h23, 1, 0, 0, 0, 32'h0, 0, 0, S_FRAME);
        add(1, 1, 1, 8'h24, 1, 0, 0, 1, 32'h24232221, 0, 0, S_FRAME);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, S_FLUSH);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, S_IDLE);
        run_vecs("enable");
        check("enable frame_pix", 32'(frame_pix), PIXCNT ? 32'd4 : 32'd0);

        // overflow: 24 pixels with ready low, clear coinciding with the last drop
        drive(1, 0, 0, 8'h00, 0, 1, 0);
        check("ovf frame_start", 32'(frame_start), 32'd1);
        for (int i = 0; i < 24; i++) begin
            drive(1, 1, 1, 8'(8'h40 + i), 0, 1, (i == 23));
            if (i == 3)  check("ovf first word valid", 32'(valid), 32'd1);
            if (i == 15) check("ovf full no drop yet", 32'(overflow), 32'd0);
            if (i == 19) check("ovf first drop", 32'(overflow), 32'd1);
        end
        check("ovf set beats clear", 32'(overflow), 32'd1);
        check("ovf head stable", data, 32'h43424140);
        drive(0, 0, 0, 8'h00, 0, 1, 0);
        drive(0, 0, 0, 8'h00, 0, 1, 0);
        check("ovf sticky", 32'(overflow), 32'd1);
        check("ovf head still stable", data, 32'h43424140);
        drive(0, 0, 0, 8'h00, 0, 1, 1);
        check("ovf cleared", 32'(overflow), 32'd0);
        cfg_clr = 1'b0;
        exp_q.push_back(32'h43424140);
        exp_q.push_back(32'h47464544);
        exp_q.push_back(32'h4B4A4948);
        exp_q.push_back(32'h4F4E4D4C);
        drain("ovf", 4);
        check("ovf frame_pix", 32'(frame_pix), PIXCNT ? 32'd24 : 32'd0);

        // full FIFO: push and pop in the same cycle
        drive(1, 0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 8'(8'h60 + i), (i == 19), 1, 0);
            if (i == 15) check("full head", data, 32'h63626160);
        end
        check("full push+pop no overflow", 32'(overflow), 32'd0);
        pix_valid = 1'b0; hsync = 1'b0;
        exp_q.push_back(32'h67666564);
        exp_q.push_back(32'h6B6A6968);
        exp_q.push_back(32'h6F6E6D6C);
        exp_q.push_back(32'h73727170);
        drain("full", 4);
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        check("full end state", 32'(state), 32'(S_IDLE));
        check("full end valid", 32'(valid), 32'd0);

        // reset mid-frame with buffered and partial words, vsync held high
        drive(1, 0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 8'(8'h31 + i), 0, 1, 0);
        check("rst pre valid", 32'(valid), 32'd1);
        rst = 1'b1;
        drive(1, 0, 0, 8'h00, 1, 1, 0);
        rst = 1'b0;
        check("rst valid", 32'(valid), 32'd0);
        check("rst state", 32'(state), 32'(S_IDLE));
        check("rst frame_pix", 32'(frame_pix), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 8'(8'h50 + i), 1, 1, 0);
            check($sformatf("rst hold%0d state", i), 32'(state), 32'(S_IDLE));
            check($sformatf("rst hold%0d frame_start", i), 32'(frame_start), 32'd0);
            check($sformatf("rst hold%0d valid", i), 32'(valid), 32'd0);
        end
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        drive(1, 0, 0, 8'h00, 1, 1, 0);
        check("rst new frame_start", 32'(frame_start), 32'd1);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 8'(8'h91 + i), 1, 1, 0);
        check("rst new word valid", 32'(valid), 32'd1);
        check("rst new word data", data, 32'h94939291);
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        check("rst end state", 32'(state), 32'(S_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
